// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state encoding and the magnitude helper.
package mdu_pkg;

   localparam int MDU_XLEN = 32;
   localparam int MDU_CNTW = 5;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   function automatic logic [MDU_XLEN-1:0] abs_val(input logic [MDU_XLEN-1:0] v);
      return v[MDU_XLEN-1] ? ({MDU_XLEN{1'b0}} - v) : v;
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial
// subtract for divide. Purely combinational.
module mdu_step
   import mdu_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic            i_div,
   input  logic [XLEN-1:0] i_hi,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_m,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shl;
   logic [XLEN-1:0] w_diff;
   logic            w_ge;

   // The carry of the add is shifted straight back into the top of hi
   assign w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : {(XLEN+1){1'b0}});
   assign w_shl  = {i_hi, i_lo[XLEN-1]};
   assign w_ge   = (w_shl >= {1'b0, i_m});
   // The partial remainder stays below the divisor, so the low bits suffice
   assign w_diff = w_shl[XLEN-1:0] - i_m;

   // Select the multiply or divide iteration result
   always_comb begin
      o_hi = i_hi;
      o_lo = i_lo;
      if (i_div) begin
         if (w_ge) begin
            o_hi = w_diff;
            o_lo = {i_lo[XLEN-2:0], 1'b1};
         end else begin
            o_hi = w_shl[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         o_hi = w_sum[XLEN:1];
         o_lo = {w_sum[0], i_lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO
// registers; 32 RUN steps on magnitudes followed by one sign-fix cycle.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int XLEN = MDU_XLEN,
   parameter int CNTW = MDU_CNTW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            wr_hi,
   input  logic            wr_lo,
   input  logic [XLEN-1:0] wd,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [CNTW-1:0]   r_cnt;
   logic [XLEN-1:0]   r_acc_hi;
   logic [XLEN-1:0]   r_acc_lo;
   logic [XLEN-1:0]   r_opnd;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic              r_is_div;
   logic              r_neg_p;
   logic              r_neg_r;
   logic              r_dz;
   logic              r_done;

   logic              w_signed;
   logic              w_is_div;
   logic              w_b_zero;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic [XLEN-1:0]   w_step_hi;
   logic [XLEN-1:0]   w_step_lo;
   logic [XLEN-1:0]   w_fix_hi;
   logic [XLEN-1:0]   w_fix_lo;
   logic [2*XLEN-1:0] w_prod_neg;

   assign w_signed = (op == OP_MULT) || (op == OP_DIV);
   assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign w_b_zero = (b == {XLEN{1'b0}});
   // Divide by zero keeps a raw: the loop then returns hi=a, lo=all ones
   assign w_a_mag  = (w_signed && !(w_is_div && w_b_zero)) ? abs_val(a) : a;
   assign w_b_mag  = w_signed ? abs_val(b) : b;

   mdu_step #(.XLEN(XLEN)) u_step (
      .i_div (r_is_div),
      .i_hi  (r_acc_hi),
      .i_lo  (r_acc_lo),
      .i_m   (r_opnd),
      .o_hi  (w_step_hi),
      .o_lo  (w_step_lo)
   );

   assign w_prod_neg = {(2*XLEN){1'b0}} - {r_acc_hi, r_acc_lo};

   // Sign correction of the magnitude result, applied in FIX
   always_comb begin
      w_fix_hi = r_acc_hi;
      w_fix_lo = r_acc_lo;
      if (r_dz) begin
         w_fix_hi = r_acc_hi;
         w_fix_lo = r_acc_lo;
      end else if (!r_is_div) begin
         if (r_neg_p) begin
            {w_fix_hi, w_fix_lo} = w_prod_neg;
         end else begin
            {w_fix_hi, w_fix_lo} = {r_acc_hi, r_acc_lo};
         end
      end else begin
         if (r_neg_p) begin
            w_fix_lo = {XLEN{1'b0}} - r_acc_lo;
         end else begin
            w_fix_lo = r_acc_lo;
         end
         if (r_neg_r) begin
            w_fix_hi = {XLEN{1'b0}} - r_acc_hi;
         end else begin
            w_fix_hi = r_acc_hi;
         end
      end
   end

   // Next-state logic: IDLE -> RUN (32 steps) -> FIX -> IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (r_cnt == CNTW'(XLEN-1)) begin
               w_state_nxt = ST_FIX;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand capture, iteration, HI/LO update and done pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= {CNTW{1'b0}};
         r_acc_hi <= {XLEN{1'b0}};
         r_acc_lo <= {XLEN{1'b0}};
         r_opnd   <= {XLEN{1'b0}};
         r_hi     <= {XLEN{1'b0}};
         r_lo     <= {XLEN{1'b0}};
         r_is_div <= 1'b0;
         r_neg_p  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == ST_FIX);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cnt    <= {CNTW{1'b0}};
                  r_acc_hi <= {XLEN{1'b0}};
                  r_is_div <= w_is_div;
                  r_neg_p  <= w_signed & (a[XLEN-1] ^ b[XLEN-1]);
                  r_neg_r  <= w_signed & a[XLEN-1];
                  r_dz     <= w_is_div & w_b_zero;
                  r_acc_lo <= w_is_div ? w_a_mag : w_b_mag;
                  r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
               end else begin
                  if (wr_hi) r_hi <= wd;
                  if (wr_lo) r_lo <= wd;
               end
            end
            ST_RUN: begin
               r_acc_hi <= w_step_hi;
               r_acc_lo <= w_step_lo;
               r_cnt    <= r_cnt + CNTW'(1);
            end
            ST_FIX: begin
               r_hi <= w_fix_hi;
               r_lo <= w_fix_lo;
            end
            default: begin
               r_cnt <= {CNTW{1'b0}};
            end
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO pushed at launch,
// popped and compared when done pulses; also checks timing, mthi/mtlo, reset.
module tb_mul_div_unit;
   import mdu_pkg::*;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wd;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   exp_t        sb_q[$];
   int          n_checks;
   int          n_fail;
   logic [31:0] arch_hi;
   logic [31:0] arch_lo;

   mul_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .wr_hi (wr_hi),
      .wr_lo (wr_lo),
      .wd    (wd),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t        r;
      longint      sx;
      longint      sy;
      longint      q;
      longint      m;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = '0;
      case (o)
         2'b00: begin
            p = sx * sy;
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         2'b01: begin
            p = {32'd0, x} * {32'd0, y};
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         default: begin
            if (y == 32'd0) begin
               r.hi = x;
               r.lo = 32'hFFFFFFFF;
            end else if (o == 2'b10) begin
               q = sx / sy;
               m = sx % sy;
               r.lo = q[31:0];
               r.hi = m[31:0];
            end else begin
               r.lo = x / y;
               r.hi = x % y;
            end
         end
      endcase
      return r;
   endfunction

   task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input bit inject);
      exp_t e;
      int   cyc;
      int   bcnt;
      bit   seen;
      sb_q.push_back(model(op_i, a_i, b_i));
      @(negedge clk);
      start = 1'b1; op = op_i; a = a_i; b = b_i;
      if (inject) begin
         wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'hDEADBEEF;
      end
      @(negedge clk);
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      op = ~op_i; a = $urandom; b = $urandom;
      cyc = 1; bcnt = 0; seen = 1'b0;
      while (!seen && cyc <= 100) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) bcnt++;
            if (inject && cyc == 20) begin
               check_eq("hi_held_busy", {32'd0, hi}, {32'd0, arch_hi});
               check_eq("lo_held_busy", {32'd0, lo}, {32'd0, arch_lo});
            end
            if (inject && (cyc == 5 || cyc == 33)) begin
               start = 1'b1; op = OP_MULTU; a = 32'h11111111; b = 32'd3;
               wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'h55AA55AA;
            end else begin
               start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      e = sb_q.pop_front();
      if (!seen) begin
         check_eq("done_timeout", 64'd0, 64'd1);
         return;
      end
      check_eq("latency", 64'(cyc), 64'd34);
      check_eq("busy_cycles", 64'(bcnt), 64'd33);
      check_eq("busy_at_done", {63'd0, busy}, 64'd0);
      check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
      check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
      arch_hi = e.hi;
      arch_lo = e.lo;
      @(negedge clk);
      check_eq("done_pulse", {63'd0, done}, 64'd0);
      check_eq("idle_after", {63'd0, busy}, 64'd0);
   endtask

   task automatic mt_write(input bit whi, input bit wlo, input logic [31:0] data);
      @(negedge clk);
      wr_hi = whi; wr_lo = wlo; wd = data;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b0;
      if (whi) arch_hi = data;
      if (wlo) arch_lo = data;
      check_eq("mt_hi", {32'd0, hi}, {32'd0, arch_hi});
      check_eq("mt_lo", {32'd0, lo}, {32'd0, arch_lo});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      n_checks = 0; n_fail = 0;
      arch_hi = 32'd0; arch_lo = 32'd0;
      reset = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
      wr_hi = 1'b0; wr_lo = 1'b0; wd = 32'd0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_done", {63'd0, done}, 64'd0);
      check_eq("rst_hilo", {hi, lo}, 64'd0);
      reset = 1'b1;

      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op(OP_MULT,  32'hFFFFFFF9, 32'd3, 1'b0);
      run_op(OP_DIV,   32'hFFFFFFF9, 32'd2, 1'b0);
      run_op(OP_DIVU,  32'd100, 32'd7, 1'b0);
      run_op(OP_DIVU,  32'h12345678, 32'd0, 1'b0);
      run_op(OP_DIV,   32'h12345678, 32'd0, 1'b0);
      run_op(OP_DIV,   32'hF0000001, 32'd0, 1'b0);
      run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(OP_MULT,  32'h80000000, 32'h80000000, 1'b0);
      run_op(OP_DIV,   32'd7, 32'hFFFFFFFE, 1'b0);
      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
         run_op(rop, ra, rb, 1'b0);
      end

      run_op(OP_MULT, 32'h00012345, 32'hFFFF0003, 1'b1);
      mt_write(1'b1, 1'b0, 32'hCAFEF00D);
      mt_write(1'b0, 1'b1, 32'h0BADC0DE);
      mt_write(1'b1, 1'b1, 32'hA5A5A5A5);

      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
      reset = 1'b0;
      #1;
      check_eq("midrun_busy", {63'd0, busy}, 64'd0);
      check_eq("midrun_done", {63'd0, done}, 64'd0);
      check_eq("midrun_hilo", {hi, lo}, 64'd0);
      arch_hi = 32'd0; arch_lo = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      run_op(OP_MULT, 32'd6, 32'd7, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
